// File: rtl/alu_arbiter_4bit.sv
// Two-requester round-robin arbiter in front of one shared 4-bit ripple add/sub unit.
// Optional macro ALU_ARB_OVF_EN adds the registered signed-overflow output ovf.
module alu_arbiter_4bit #(
  parameter bit START_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic       sel0,
  input  logic       sel1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] result,
  output logic       cout,
`ifdef ALU_ARB_OVF_EN
  output logic       ovf,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GRANT, EXEC, DONE} state_t;

  state_t     state, state_nxt;
  logic       winner;
  logic       win_nxt;
  logic       prio;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       op_sel;
  logic [3:0] bx;
  logic [4:0] carry;
  logic [3:0] sum;
  logic       sum_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    win_nxt   = (req0 && req1) ? prio : req1;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = GRANT;
      GRANT:   state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shared ripple adder: subtract is A + ~B + 1, so carry-out means "no borrow".
  always_comb begin
    bx       = op_b ^ {4{op_sel}};
    carry    = '0;
    carry[0] = op_sel;
    sum      = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i]     = op_a[i] ^ bx[i] ^ carry[i];
      carry[i+1] = (op_a[i] & bx[i]) | (carry[i] & (op_a[i] ^ bx[i]));
    end
    sum_ovf = (op_a[3] == bx[3]) && (sum[3] != op_a[3]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      winner <= 1'b0;
      prio   <= START_PRIO;
      op_a   <= '0;
      op_b   <= '0;
      op_sel <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
`ifdef ALU_ARB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req0 || req1) winner <= win_nxt;
        GRANT: begin
          op_a   <= winner ? a1 : a0;
          op_b   <= winner ? b1 : b0;
          op_sel <= winner ? sel1 : sel0;
        end
        EXEC: begin
          result <= sum;
          cout   <= carry[4];
`ifdef ALU_ARB_OVF_EN
          ovf    <= sum_ovf;
`endif
        end
        DONE: prio <= ~winner;
        default: ;
      endcase
    end
  end

`ifndef ALU_ARB_OVF_EN
  logic unused_ovf;
  assign unused_ovf = sum_ovf;
`endif

  assign gnt0  = (state == GRANT) && !winner;
  assign gnt1  = (state == GRANT) &&  winner;
  assign done0 = (state == DONE)  && !winner;
  assign done1 = (state == DONE)  &&  winner;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter_4bit.sv
// Scoreboard bench for alu_arbiter_4bit: expected ops queued at issue, checked at done.
module tb_alu_arbiter_4bit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       sel0 = 1'b0, sel1 = 1'b0;
  logic       gnt0, gnt1, done0, done1, cout, busy;
  logic [3:0] result;
`ifdef ALU_ARB_OVF_EN
  logic       ovf;
`endif

  alu_arbiter_4bit dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sel0(sel0), .sel1(sel1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .cout(cout),
`ifdef ALU_ARB_OVF_EN
    .ovf(ovf),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       who;
    logic [3:0] res;
    logic       c;
    logic       v;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  function automatic exp_t model(input logic who, input logic [3:0] a, input logic [3:0] b,
                                 input logic sel, input int dc);
    exp_t e;
    int   sa, sb, r;
    e.who = who;
    e.cyc = dc;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    if (sel) begin
      e.res = 4'((int'(a) - int'(b)) & 15);
      e.c   = (int'(a) >= int'(b));
      r     = sa - sb;
    end else begin
      e.res = 4'((int'(a) + int'(b)) & 15);
      e.c   = (int'(a) + int'(b)) > 15;
      r     = sa + sb;
    end
    e.v = (r > 7) || (r < -8);
    return e;
  endfunction

  task automatic issue(input logic who, input logic [3:0] a, input logic [3:0] b,
                       input logic sel, input int dc);
    if (who) begin req1 = 1'b1; a1 = a; b1 = b; sel1 = sel; end
    else     begin req0 = 1'b1; a0 = a; b0 = b; sel0 = sel; end
    exp_q.push_back(model(who, a, b, sel, dc));
  endtask

  // Runs until n_ops completions; drops requests at the drop_after-th grant and
  // scrambles all operands one cycle later, while the op is already latched.
  task automatic run(input int n_ops, input int drop_after, input int budget);
    int   gnts = 0;
    int   scramble_at = -1;
    logic exp_busy;
    exp_t e;
    for (int k = 0; k < budget && n_ops > 0; k++) begin
      @(negedge clk);
      cyc++;
      if (cyc == scramble_at) begin
        a0 = 4'($urandom); b0 = 4'($urandom); sel0 = 1'($urandom);
        a1 = 4'($urandom); b1 = 4'($urandom); sel1 = 1'($urandom);
      end
      tests++;
      if ((gnt0 && gnt1) || (done0 && done1)) begin
        fails++;
        $display("FAIL exclusive cyc=%0d gnt=%b%b done=%b%b required at most one high",
                 cyc, gnt1, gnt0, done1, done0);
      end
      if (exp_q.size() > 0) begin
        exp_busy = (cyc >= exp_q[0].cyc - 2) && (cyc <= exp_q[0].cyc);
        tests++;
        if (busy !== exp_busy) begin
          fails++;
          $display("FAIL busy cyc=%0d got %b required %b", cyc, busy, exp_busy);
        end
      end
      if (gnt0 || gnt1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL gnt cyc=%0d got unexpected grant required none", cyc);
        end else if (gnt1 !== exp_q[0].who || cyc !== exp_q[0].cyc - 2) begin
          fails++;
          $display("FAIL gnt cyc=%0d got gnt1=%b required who=%b at cyc %0d",
                   cyc, gnt1, exp_q[0].who, exp_q[0].cyc - 2);
        end
        gnts++;
        if (gnts == drop_after) begin
          req0 = 1'b0;
          req1 = 1'b0;
          scramble_at = cyc + 1;
        end
      end
      if (done0 || done1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL done cyc=%0d got unexpected done required none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (done1 !== e.who || cyc !== e.cyc || result !== e.res || cout !== e.c) begin
            fails++;
            $display("FAIL done cyc=%0d got who=%b res=%0d cout=%b required who=%b res=%0d cout=%b cyc=%0d",
                     cyc, done1, result, cout, e.who, e.res, e.c, e.cyc);
          end
`ifdef ALU_ARB_OVF_EN
          tests++;
          if (ovf !== e.v) begin
            fails++;
            $display("FAIL ovf cyc=%0d got %b required %b", cyc, ovf, e.v);
          end
`endif
        end
        n_ops--;
      end
    end
    if (n_ops > 0) begin
      fails++;
      $display("FAIL timeout %0d ops outstanding after %0d cycles", n_ops, budget);
      exp_q.delete();
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) begin
      fails++;
      $display("FAIL settle got busy=%b done=%b%b required all 0", busy, done1, done0);
    end
    cyc = 0;
  endtask

  task automatic check_zero(input string tag);
    tests++;
    if ({gnt0, gnt1, done0, done1, busy, cout, result} !== 9'b0) begin
      fails++;
      $display("FAIL %s got gnt=%b%b done=%b%b busy=%b cout=%b res=%0d required all 0",
               tag, gnt1, gnt0, done1, done0, busy, cout, result);
    end
`ifdef ALU_ARB_OVF_EN
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL %s_ovf got %b required 0", tag, ovf);
    end
`endif
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
  endtask

  task automatic test_single_add();
    cyc = 0;
    issue(1'b0, 4'd3, 4'd5, 1'b0, 3);
    run(1, 1, 20);
  endtask

  task automatic test_subtract();
    cyc = 0; issue(1'b1, 4'd9,  4'd9, 1'b1, 3); run(1, 1, 20);
    cyc = 0; issue(1'b1, 4'd2,  4'd5, 1'b1, 3); run(1, 1, 20);
    cyc = 0; issue(1'b1, 4'd15, 4'd1, 1'b0, 3); run(1, 1, 20);
  endtask

  task automatic test_round_robin();
    // Pointer starts at 0: 0, 1, then 0 again while both stay asserted.
    cyc = 0;
    issue(1'b0, 4'd4, 4'd6, 1'b0, 3);
    issue(1'b1, 4'd12, 4'd3, 1'b1, 7);
    exp_q.push_back(model(1'b0, 4'd4, 4'd6, 1'b0, 11));
    run(3, 3, 40);
    // Last served was 0, so 1 now holds priority.
    cyc = 0;
    issue(1'b0, 4'd1, 4'd14, 1'b0, 7);
    issue(1'b1, 4'd7, 4'd8, 1'b1, 3);
    exp_q.pop_front();
    exp_q.push_back(model(1'b0, 4'd1, 4'd14, 1'b0, 7));
    run(2, 2, 30);
  endtask

  task automatic test_ovf_cases();
    cyc = 0; issue(1'b0, 4'd7, 4'd1, 1'b0, 3); run(1, 1, 20);
    cyc = 0; issue(1'b1, 4'd8, 4'd1, 1'b1, 3); run(1, 1, 20);
  endtask

  task automatic test_random();
    logic w;
    for (int i = 0; i < 8; i++) begin
      w = 1'(i);
      cyc = 0;
      issue(w, 4'($urandom), 4'($urandom), 1'($urandom), 3);
      run(1, 1, 20);
    end
  endtask

  task automatic test_reset_mid();
    cyc = 0; issue(1'b0, 4'd5, 4'd6, 1'b0, 3); run(1, 1, 20);
    req0 = 1'b1; a0 = 4'd4; b0 = 4'd4; sel0 = 1'b0;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_zero("reset_exec");
    @(negedge clk);
    check_zero("reset_hold");
    reset = 1'b0;
    cyc = 0;
    issue(1'b1, 4'd10, 4'd3, 1'b1, 3);
    run(1, 1, 20);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_subtract();
    test_round_robin();
    test_ovf_cases();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
